tcp_rx_notify_handler: RTL

//  Turns TOE rx notifications into read requests and delivers one session's payload at a time to the HTTP engine.

---
 rtl/tcp_rx_notify_handler_pkg.sv | 43 ++++
 rtl/tcp_rx_notify_handler_if.sv | 81 ++++++++
 rtl/tcp_rx_notify_handler_notif_fifo.sv | 53 +++++
 rtl/tcp_rx_notify_handler.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tcp_rx_notify_handler_pkg.sv
// Shared types for the TOE rx notification handler: notification/read-request layouts, FSM states, keep popcount.
// No logic here; latency and backpressure belong to the modules that use these types.
// Field order inside the packed structs matches the TOE bit layout, so a struct maps 1:1 onto the bus.
package tcp_rx_notify_handler_pkg;

    localparam int SESSION_W  = 16;
    localparam int LEN_W      = 16;
    localparam int CNT_W      = LEN_W + 1;
    localparam int MAX_KEEP_W = 128;

    typedef struct packed {
        logic [6:0]           rsvd;
        logic                 closed;
        logic [15:0]          port;
        logic [31:0]          ip;
        logic [LEN_W-1:0]     length;
        logic [SESSION_W-1:0] session;
    } notif_t;

    typedef struct packed {
        logic [LEN_W-1:0]     length;
        logic [SESSION_W-1:0] session;
    } rdreq_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_META,
        ST_DATA,
        ST_CLOSE
    } state_t;

    // Callers zero-extend keep to MAX_KEEP_W, so one function serves any DATA_W up to 1024.
    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_KEEP_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/tcp_rx_notify_handler_if.sv
// Bundles the TOE-facing and HTTP-facing handshakes plus status of the rx notify handler.
// slave is the handler's view, master the view of the logic around it.
// Backpressure is plain valid/ready on every channel.
interface tcp_rx_notify_handler_if #(
    parameter int DATA_W = 512
);
    import tcp_rx_notify_handler_pkg::*;

    logic                  notif_valid;
    logic                  notif_ready;
    notif_t                notif_data;

    logic                  rdreq_valid;
    logic                  rdreq_ready;
    rdreq_t                rdreq_data;

    logic                  rxmeta_valid;
    logic                  rxmeta_ready;
    logic [SESSION_W-1:0]  rxmeta_data;

    logic                  rxd_valid;
    logic                  rxd_ready;
    logic [DATA_W-1:0]     rxd_data;
    logic [DATA_W/8-1:0]   rxd_keep;
    logic                  rxd_last;

    logic                  app_meta_valid;
    logic                  app_meta_ready;
    logic [31:0]           app_meta_data;

    logic                  app_d_valid;
    logic                  app_d_ready;
    logic [DATA_W-1:0]     app_d_data;
    logic [DATA_W/8-1:0]   app_d_keep;
    logic                  app_d_last;

    logic                  app_close_valid;
    logic                  app_close_ready;
    logic [SESSION_W-1:0]  app_close_session;

    logic                  err_len;
    logic                  err_sess;
    logic [31:0]           stat_reads;

    modport slave (
        input  notif_valid, notif_data,
        output notif_ready,
        output rdreq_valid, rdreq_data,
        input  rdreq_ready,
        input  rxmeta_valid, rxmeta_data,
        output rxmeta_ready,
        input  rxd_valid, rxd_data, rxd_keep, rxd_last,
        output rxd_ready,
        output app_meta_valid, app_meta_data,
        input  app_meta_ready,
        output app_d_valid, app_d_data, app_d_keep, app_d_last,
        input  app_d_ready,
        output app_close_valid, app_close_session,
        input  app_close_ready,
        output err_len, err_sess, stat_reads
    );

    modport master (
        output notif_valid, notif_data,
        input  notif_ready,
        input  rdreq_valid, rdreq_data,
        output rdreq_ready,
        output rxmeta_valid, rxmeta_data,
        input  rxmeta_ready,
        output rxd_valid, rxd_data, rxd_keep, rxd_last,
        input  rxd_ready,
        input  app_meta_valid, app_meta_data,
        output app_meta_ready,
        input  app_d_valid, app_d_data, app_d_keep, app_d_last,
        output app_d_ready,
        input  app_close_valid, app_close_session,
        output app_close_ready,
        input  err_len, err_sess, stat_reads
    );

endinterface

// File: rtl/tcp_rx_notify_handler_notif_fifo.sv
// Generic synchronous FIFO; head word is read straight from the storage flops.
// Latency: a write is visible at the head one cycle later.
// Backpressure: full blocks writes unless a pop happens in the same cycle.
module tcp_notif_fifo #(
    parameter int WIDTH = 88,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd  = rd_en && !empty;
    assign do_wr  = wr_vld && (!full || do_rd);
    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/tcp_rx_notify_handler.sv
// Queues TOE rx notifications, issues one read at a time and forwards meta/payload/close to the HTTP stage.
// Latency: notification accepted in cycle N -> rdreq_valid in N+2; meta and data pass through combinationally.
// Backpressure: TOE channels are stalled (ready=0) outside their FSM state, nothing is ever dropped.
module tcp_rx_notify_handler
    import tcp_rx_notify_handler_pkg::*;
#(
    parameter int DATA_W     = 512,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    tcp_rx_notify_handler_if.slave        bus
);

    localparam int KEEP_W = DATA_W / 8;

    state_t                state_q, state_d;
    logic [SESSION_W-1:0]  cur_session_q, cur_session_d;
    logic [LEN_W-1:0]      cur_length_q, cur_length_d;
    logic                  cur_closed_q, cur_closed_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic                  err_len_q, err_len_d;
    logic                  err_sess_q, err_sess_d;
    logic [31:0]           stat_reads_q, stat_reads_d;

    notif_t                fifo_head;
    logic                  fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [MAX_KEEP_W-1:0] keep_ext;
    logic [CNT_W:0]        byte_sum;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  unused_head;

    // Gating with reset keeps intake closed while the FIFO is being flushed.
    assign bus.notif_ready = !fifo_full && !ap_rst;
    assign fifo_push       = bus.notif_valid && bus.notif_ready;

    tcp_notif_fifo #(
        .WIDTH ($bits(notif_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_notif_fifo (
        .clk    (ap_clk),
        .rst    (ap_rst),
        .wr_vld (fifo_push),
        .wr_dat (bus.notif_data),
        .rd_en  (fifo_pop),
        .rd_dat (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign unused_head = ^{fifo_head.rsvd, fifo_head.port, fifo_head.ip};

    always_comb begin
        keep_ext               = '0;
        keep_ext[KEEP_W-1:0]   = bus.rxd_keep;
    end

    // Running count including the current beat, saturating at all-ones.
    assign byte_sum = {1'b0, byte_cnt_q} + {1'b0, popcount(keep_ext)};
    assign beat_cnt = byte_sum[CNT_W] ? {CNT_W{1'b1}} : byte_sum[CNT_W-1:0];

    always_comb begin
        state_d            = state_q;
        cur_session_d      = cur_session_q;
        cur_length_d       = cur_length_q;
        cur_closed_d       = cur_closed_q;
        byte_cnt_d         = byte_cnt_q;
        err_len_d          = err_len_q;
        err_sess_d         = err_sess_q;
        stat_reads_d       = stat_reads_q;
        fifo_pop           = 1'b0;
        bus.rdreq_valid     = 1'b0;
        bus.rxmeta_ready    = 1'b0;
        bus.app_meta_valid  = 1'b0;
        bus.rxd_ready       = 1'b0;
        bus.app_d_valid     = 1'b0;
        bus.app_close_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    cur_session_d = fifo_head.session;
                    cur_length_d  = fifo_head.length;
                    cur_closed_d  = fifo_head.closed;
                    if (fifo_head.length != '0) begin
                        state_d = ST_REQ;
                    end else if (fifo_head.closed) begin
                        state_d = ST_CLOSE;
                    end
                end
            end
            ST_REQ: begin
                bus.rdreq_valid = 1'b1;
                if (bus.rdreq_ready) state_d = ST_META;
            end
            ST_META: begin
                bus.rxmeta_ready   = bus.app_meta_ready;
                bus.app_meta_valid = bus.rxmeta_valid;
                if (bus.rxmeta_valid && bus.app_meta_ready) begin
                    if (bus.rxmeta_data != cur_session_q) err_sess_d = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                bus.rxd_ready   = bus.app_d_ready;
                bus.app_d_valid = bus.rxd_valid;
                if (bus.rxd_valid && bus.app_d_ready) begin
                    byte_cnt_d = beat_cnt;
                    if (bus.rxd_last) begin
                        if (beat_cnt != {1'b0, cur_length_q}) err_len_d = 1'b1;
                        stat_reads_d = stat_reads_q + 32'd1;
                        state_d      = cur_closed_q ? ST_CLOSE : ST_IDLE;
                    end
                end
            end
            ST_CLOSE: begin
                bus.app_close_valid = 1'b1;
                if (bus.app_close_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= ST_IDLE;
            cur_session_q <= '0;
            cur_length_q  <= '0;
            cur_closed_q  <= 1'b0;
            byte_cnt_q    <= '0;
            err_len_q     <= 1'b0;
            err_sess_q    <= 1'b0;
            stat_reads_q  <= '0;
        end else begin
            state_q       <= state_d;
            cur_session_q <= cur_session_d;
            cur_length_q  <= cur_length_d;
            cur_closed_q  <= cur_closed_d;
            byte_cnt_q    <= byte_cnt_d;
            err_len_q     <= err_len_d;
            err_sess_q    <= err_sess_d;
            stat_reads_q  <= stat_reads_d;
        end
    end

    assign bus.rdreq_data        = '{length: cur_length_q, session: cur_session_q};
    assign bus.app_meta_data     = {cur_length_q, bus.rxmeta_data};
    assign bus.app_d_data        = bus.rxd_data;
    assign bus.app_d_keep        = bus.rxd_keep;
    assign bus.app_d_last        = bus.rxd_last;
    assign bus.app_close_session = cur_session_q;
    assign bus.err_len           = err_len_q;
    assign bus.err_sess          = err_sess_q;
    assign bus.stat_reads        = stat_reads_q;

endmodule
